// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts spikes on three input lines over a window of
// enabled cycles. It latches the window length at the start of each window
// and emits one result per window through a valid/ready handshake. The output
// register holds one result. A result that finishes while the previous one is
// still waiting downstream is dropped, and the sticky overrun flag is set.
//
// Build option: define SPIKE_RATE_SAT_EN to make the accumulator and result
// saturate at 2^CNT_W-1. Without it they wrap modulo 2^CNT_W.
module spike_rate_decoder #(
   parameter int CNT_W = 8,
   parameter int SEQ_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [2:0]       spike_in,
   input  logic [7:0]       window_len,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [CNT_W-1:0] out_count,
   output logic [SEQ_W-1:0] out_seq,
   output logic             overrun
);

   // LOAD_LEN is the first enabled cycle of a window. It latches the length
   // and counts that cycle's spikes. ACCUM covers the remaining window cycles.
   typedef enum logic {
      LOAD_LEN = 1'b0,
      ACCUM    = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [7:0]       len_q;        // latched window length minus one
   logic [7:0]       win_cnt;      // index of the current cycle within the window
   logic [7:0]       win_cnt_nxt;
   logic [7:0]       cur_len;      // length that applies to this cycle
   logic [7:0]       cur_idx;      // index that applies to this cycle
   logic [CNT_W-1:0] acc;
   logic [CNT_W-1:0] acc_nxt;
   logic [CNT_W-1:0] sum;          // acc plus this cycle's popcount
   logic [1:0]       pop;
   logic [SEQ_W-1:0] seq;
   logic             win_end;
   logic             xfer;
   logic             stalled;
   logic             load;
   logic             drop;

   // Popcount of the three spike lines (0..3).
   always_comb begin
      pop = {1'b0, spike_in[0]} + {1'b0, spike_in[1]} + {1'b0, spike_in[2]};
   end

`ifdef SPIKE_RATE_SAT_EN
   logic [CNT_W:0] sum_wide;

   // Saturating add. The extra carry bit detects overflow past 2^CNT_W-1.
   always_comb begin
      sum_wide = {1'b0, acc} + (CNT_W+1)'(pop);
      sum      = sum_wide[CNT_W] ? {CNT_W{1'b1}} : sum_wide[CNT_W-1:0];
   end
`else
   // Wrapping add, modulo 2^CNT_W.
   always_comb begin
      sum = acc + CNT_W'(pop);
   end
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= LOAD_LEN;
      else       state <= state_nxt;
   end

   // Next-state logic and window bookkeeping. In LOAD_LEN the live
   // window_len and index 0 apply, so window_len=0 ends the window on the
   // same cycle it starts.
   always_comb begin
      state_nxt   = state;
      win_cnt_nxt = win_cnt;
      acc_nxt     = acc;
      win_end     = 1'b0;
      cur_len     = (state == LOAD_LEN) ? window_len : len_q;
      cur_idx     = (state == LOAD_LEN) ? 8'd0 : win_cnt;
      if (enable) begin
         win_end = (cur_idx == cur_len);
         if (win_end) begin
            state_nxt   = LOAD_LEN;
            win_cnt_nxt = 8'd0;
            acc_nxt     = '0;
         end else begin
            state_nxt   = ACCUM;
            win_cnt_nxt = cur_idx + 8'd1;
            acc_nxt     = sum;
         end
      end
   end

   // Window counter, accumulator and latched length. All of them hold while
   // enable is low.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         win_cnt <= 8'd0;
         acc     <= '0;
         len_q   <= 8'd0;
      end else if (enable) begin
         win_cnt <= win_cnt_nxt;
         acc     <= acc_nxt;
         if (state == LOAD_LEN) len_q <= window_len;
      end
   end

   // A window end loads the result unless the output register is occupied
   // and not draining this cycle. In that case the new result is dropped.
   always_comb begin
      xfer    = out_valid & out_ready;
      stalled = out_valid & ~out_ready;
      load    = win_end & ~stalled;
      drop    = win_end & stalled;
   end

   // Output register, sequence counter and sticky overrun flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_count <= '0;
         out_seq   <= '0;
         overrun   <= 1'b0;
         seq       <= '0;
      end else begin
         if (load) begin
            out_valid <= 1'b1;
            out_count <= sum;
            out_seq   <= seq;
         end else if (xfer) begin
            out_valid <= 1'b0;
         end
         if (drop)    overrun <= 1'b1;
         if (win_end) seq     <= seq + SEQ_W'(1);
      end
   end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench for spike_rate_decoder: expected results are queued
// when a scenario is set up and popped on each output transfer.
module tb_spike_rate_decoder;

   typedef struct {
      logic [7:0] count;
      logic [3:0] seq;
   } res_t;

`ifdef SPIKE_RATE_SAT_EN
   localparam logic [7:0] LONG_EXP = 8'd255;
`else
   localparam logic [7:0] LONG_EXP = 8'd0;
`endif

   logic       clk;
   logic       reset;
   logic       enable;
   logic [2:0] spike_in;
   logic [7:0] window_len;
   logic       out_ready;
   logic       out_valid;
   logic [7:0] out_count;
   logic [3:0] out_seq;
   logic       overrun;

   res_t exp_q[$];
   int   total;
   int   bad;

   spike_rate_decoder #(.CNT_W(8), .SEQ_W(4)) dut (
      .clk(clk), .reset(reset), .enable(enable), .spike_in(spike_in),
      .window_len(window_len), .out_ready(out_ready), .out_valid(out_valid),
      .out_count(out_count), .out_seq(out_seq), .overrun(overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called at a negedge with the inputs already set: checks any transfer
   // that the coming posedge will perform, then advances one cycle.
   task automatic step();
      res_t e;
      if (out_valid && out_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL xfer_unexpected: got count=%0d seq=%0d, required no transfer", out_count, out_seq);
         end else begin
            e = exp_q.pop_front();
            if (out_count !== e.count || out_seq !== e.seq) begin
               bad++;
               $display("FAIL xfer: got count=%0d seq=%0d, required count=%0d seq=%0d",
                        out_count, out_seq, e.count, e.seq);
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_until_empty(input int budget, output int used);
      used = 0;
      while (exp_q.size() > 0 && used < budget) begin
         step();
         used++;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL timeout: %0d results still pending after %0d cycles, required 0", exp_q.size(), used);
         exp_q.delete();
      end
   endtask

   task automatic push(input logic [7:0] c, input logic [3:0] s);
      res_t e;
      e.count = c;
      e.seq   = s;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      enable = 1'b0; spike_in = 3'b000; out_ready = 1'b0; window_len = 8'd3;
      reset = 1'b1;
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; spike_in = 3'b000; out_ready = 1'b0; window_len = 8'd0;
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
      total++; if (out_count !== 8'd0) begin bad++; $display("FAIL reset_count: got %0d, required 0", out_count); end
      total++; if (out_seq !== 4'd0)   begin bad++; $display("FAIL reset_seq: got %0d, required 0", out_seq); end
      total++; if (overrun !== 1'b0)   begin bad++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      int used;
      do_reset();
      window_len = 8'd3; spike_in = 3'b001; enable = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) push(8'd4, 4'(i));
      run_until_empty(40, used);
      total++;
      if (used !== 17) begin bad++; $display("FAIL basic_timing: got %0d cycles, required 17", used); end
   endtask

   task automatic test_len0();
      do_reset();
      window_len = 8'd0; spike_in = 3'b111; enable = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 6; i++) push(8'd3, 4'(i));
      for (int i = 0; i < 7; i++) begin
         step();
         total++;
         if (out_valid !== 1'b1) begin bad++; $display("FAIL len0_valid: cycle %0d got %b, required 1", i, out_valid); end
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL len0_drain: got %0d pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_long();
      int used;
      do_reset();
      window_len = 8'd255; spike_in = 3'b111; enable = 1'b1; out_ready = 1'b1;
      push(LONG_EXP, 4'd0);
      run_until_empty(300, used);
      total++;
      if (used !== 257) begin bad++; $display("FAIL long_timing: got %0d cycles, required 257", used); end
   endtask

   task automatic test_overrun();
      int used;
      do_reset();
      window_len = 8'd3; spike_in = 3'b001; enable = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < 4; i++) step();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ovr_first_valid: got %b, required 1", out_valid); end
      total++; if (overrun !== 1'b0)   begin bad++; $display("FAIL ovr_early: got %b, required 0", overrun); end
      for (int i = 0; i < 4; i++) step();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ovr_held_valid: got %b, required 1", out_valid); end
      total++; if (out_count !== 8'd4) begin bad++; $display("FAIL ovr_held_count: got %0d, required 4", out_count); end
      total++; if (out_seq !== 4'd0)   begin bad++; $display("FAIL ovr_held_seq: got %0d, required 0", out_seq); end
      total++; if (overrun !== 1'b1)   begin bad++; $display("FAIL ovr_set: got %b, required 1", overrun); end
      out_ready = 1'b1;
      push(8'd4, 4'd0);
      push(8'd4, 4'd2);
      run_until_empty(20, used);
      total++; if (overrun !== 1'b1)   begin bad++; $display("FAIL ovr_sticky: got %b, required 1", overrun); end
   endtask

   task automatic test_enable_gap();
      int used;
      do_reset();
      window_len = 8'd3; spike_in = 3'b001; enable = 1'b1; out_ready = 1'b1;
      push(8'd4, 4'd0);
      step();
      window_len = 8'd0;               // mid-window change must be ignored
      step();
      enable = 1'b0; spike_in = 3'b111;
      for (int i = 0; i < 5; i++) step();
      enable = 1'b1; spike_in = 3'b001;
      run_until_empty(20, used);
      window_len = 8'd3;
      total++;
      if (used !== 3) begin bad++; $display("FAIL gap_timing: got %0d cycles, required 3", used); end
   endtask

   task automatic test_reset_mid();
      int used;
      do_reset();
      window_len = 8'd3; spike_in = 3'b001; enable = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < 6; i++) step();   // result held, second window has acc=2
      reset = 1'b1;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b, required 0", out_valid); end
      total++; if (out_count !== 8'd0) begin bad++; $display("FAIL rmid_count: got %0d, required 0", out_count); end
      total++; if (out_seq !== 4'd0)   begin bad++; $display("FAIL rmid_seq: got %0d, required 0", out_seq); end
      total++; if (overrun !== 1'b0)   begin bad++; $display("FAIL rmid_overrun: got %b, required 0", overrun); end
      window_len = 8'd1;
      @(negedge clk);
      reset = 1'b0; out_ready = 1'b1;
      push(8'd2, 4'd0);
      run_until_empty(10, used);
      total++;
      if (used !== 3) begin bad++; $display("FAIL rmid_timing: got %0d cycles, required 3", used); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_basic();
      test_len0();
      test_long();
      test_overrun();
      test_enable_gap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
